fp_acc_seq: RTL

//   Upstream sequencer for fp_acc. Accepts a start command with an element count and

---
 rtl/fp_acc_seq_if.sv | 28 ++
 rtl/fp_acc_seq.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/fp_acc_seq_if.sv
// Stream, fp_acc and result-port signals shared by fp_acc_seq and whatever sits around it.
// The slave modport is the sequencer's view; the master modport is the environment's view.
interface fp_acc_seq_if;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] acc_x;
    logic        acc_n;
    logic        acc_en;
    logic [31:0] acc_r;
    logic        acc_xo;
    logic        acc_xu;
    logic        acc_ao;
    logic [31:0] out_data;
    logic [2:0]  out_flags;
    logic        out_valid;
    logic        out_ready;

    modport slave (
        input  in_data, in_valid, acc_r, acc_xo, acc_xu, acc_ao, out_ready,
        output in_ready, acc_x, acc_n, acc_en, out_data, out_flags, out_valid
    );

    modport master (
        output in_data, in_valid, acc_r, acc_xo, acc_xu, acc_ao, out_ready,
        input  in_ready, acc_x, acc_n, acc_en, out_data, out_flags, out_valid
    );
endinterface

// File: rtl/fp_acc_seq.sv
// Feeds a counted burst of floats into fp_acc, drains its pipeline and holds the sum for pickup.
// Define FP_ACC_SEQ_FLAGS_EN to report {ao,xu,xo} per job on out_flags; otherwise out_flags is 0.
//
//   state | meaning
//   IDLE  | waiting for start
//   FEED  | accepting len elements into fp_acc
//   DRAIN | pushing zeros for LATENCY cycles so the last sum reaches acc_r
//   DONE  | result held on out_data until out_ready
module fp_acc_seq #(
    parameter int LATENCY = 8,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    output logic             busy,
    fp_acc_seq_if.slave      bus
);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] drn_q, drn_d;
    logic [31:0]      out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             acc_en;

    assign acc_en        = ((state_q == FEED) && bus.in_valid) || (state_q == DRAIN);
    assign bus.acc_en    = acc_en;
    assign bus.in_ready  = (state_q == FEED);
    assign bus.acc_x     = (state_q == FEED) ? bus.in_data : 32'h0;
    // A count of zero marks the first element of the job, so a stalled first beat keeps acc_n pending.
    assign bus.acc_n     = (state_q == FEED) && bus.in_valid && (cnt_q == '0);
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign busy          = (state_q != IDLE);

`ifdef FP_ACC_SEQ_FLAGS_EN
    logic       xo_q, xo_d;
    logic       xu_q, xu_d;
    logic [2:0] flags_q, flags_d;

    assign bus.out_flags = flags_q;
`else
    logic unused_flag_in;

    assign unused_flag_in = bus.acc_xo | bus.acc_xu | bus.acc_ao;
    assign bus.out_flags  = 3'b000;
`endif

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        drn_d       = drn_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
`ifdef FP_ACC_SEQ_FLAGS_EN
        xo_d    = xo_q | (acc_en & bus.acc_xo);
        xu_d    = xu_q | (acc_en & bus.acc_xu);
        flags_d = flags_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d = len;
                    cnt_d = '0;
`ifdef FP_ACC_SEQ_FLAGS_EN
                    xo_d    = 1'b0;
                    xu_d    = 1'b0;
                    flags_d = 3'b000;
`endif
                    if (len == '0) begin
                        state_d     = DONE;
                        out_data_d  = 32'h0;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = FEED;
                    end
                end
            end
            FEED: begin
                if (bus.in_valid) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == len_q - CNT_W'(1)) begin
                        state_d = DRAIN;
                        drn_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            DRAIN: begin
                if (drn_q == '0) begin
                    state_d     = DONE;
                    out_data_d  = bus.acc_r;
                    out_valid_d = 1'b1;
`ifdef FP_ACC_SEQ_FLAGS_EN
                    flags_d = {bus.acc_ao, xu_d, xo_d};
`endif
                end else begin
                    drn_d = drn_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            drn_q       <= '0;
            out_data_q  <= 32'h0;
            out_valid_q <= 1'b0;
`ifdef FP_ACC_SEQ_FLAGS_EN
            xo_q    <= 1'b0;
            xu_q    <= 1'b0;
            flags_q <= 3'b000;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            drn_q       <= drn_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
`ifdef FP_ACC_SEQ_FLAGS_EN
            xo_q    <= xo_d;
            xu_q    <= xu_d;
            flags_q <= flags_d;
`endif
        end
    end

endmodule
